// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the PC, drives a synchronous
//             1-cycle-latency instruction ROM, buffers returned words in a
//             prefetch queue and hands them to decode over valid/ready.
//             Redirects (jr > jump > taken branch) flush the queue and use
//             an epoch bit to discard the word still in flight.
//  Options  : FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_flushes.
//  Limits   : QDEPTH power of 2 and >= 2; ADDR_W <= 25.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 32,
    parameter int IMM_W    = 16,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_q,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic [IMM_W-1:0]   br_imm,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    input  logic               jr,
    input  logic [31:0]        jr_addr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [15:0]        perf_flushes
`endif
);

    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // One spare bit above the wider operand guarantees non-empty padding.
    localparam int c_EXT_W = ((IMM_W > ADDR_W) ? IMM_W : ADDR_W) + 1;
    localparam logic [ADDR_W-1:0]  c_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(QDEPTH);

    // PC / in-flight tracking
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_epoch;
    logic               r_inflight;
    logic               r_tag_epoch;
    logic [ADDR_W-1:0]  r_tag_pc;

    // Prefetch queue
    logic [INSTR_W-1:0] r_q_instr [QDEPTH];
    logic [ADDR_W-1:0]  r_q_pc    [QDEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Control
    logic               w_redirect;
    logic [ADDR_W-1:0]  w_target;
    logic [c_EXT_W-1:0] w_br_sum;
    logic [ADDR_W-1:0]  w_br_target;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_bits;

    assign w_redirect = jr | jump | br_taken;

    // Branch target: br_pc + 1 + sext(br_imm), wrapped to the address space.
    assign w_br_sum = {{(c_EXT_W-ADDR_W){1'b0}}, br_pc}
                    + c_EXT_W'(1)
                    + {{(c_EXT_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
    assign w_br_target = w_br_sum[ADDR_W-1:0];

    // Bits above the address width carry no information for this stage.
    assign w_unused_bits = ^{jr_addr[31:ADDR_W], jump_index[25:ADDR_W],
                             w_br_sum[c_EXT_W-1:ADDR_W]};

    // Redirect target selection, jr has highest priority, branch lowest.
    always_comb begin
        w_target = w_br_target;
        if (jr) begin
            w_target = jr_addr[ADDR_W-1:0];
        end else if (jump) begin
            w_target = jump_index[ADDR_W-1:0];
        end
    end

    // Reserve a queue slot for every word in flight so a return never overflows.
    assign w_issue = !w_redirect && ((r_count + c_CNT_W'(r_inflight)) < c_DEPTH);
    // A returning word is kept only if no redirect happened since it was issued.
    assign w_push  = r_inflight && (r_tag_epoch == r_epoch) && !w_redirect;
    assign w_pop   = out_valid && out_ready;

    assign rom_addr  = r_fetch_pc;
    assign out_valid = (r_count != '0);
    assign out_instr = r_q_instr[r_rd_ptr];
    assign out_pc    = r_q_pc[r_rd_ptr];

    // PC advance, redirect handling and tagging of the word being fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc  <= c_RESET_PC;
            r_epoch     <= 1'b0;
            r_inflight  <= 1'b0;
            r_tag_epoch <= 1'b0;
            r_tag_pc    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_epoch    <= ~r_epoch;
            end else if (w_issue) begin
                r_fetch_pc  <= r_fetch_pc + ADDR_W'(1);
                r_tag_epoch <= r_epoch;
                r_tag_pc    <= r_fetch_pc;
            end
        end
    end

    // Queue storage: written on push, contents otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_q_instr[r_wr_ptr] <= rom_q;
            r_q_pc[r_wr_ptr]    <= r_tag_pc;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [15:0] r_perf_flushes;
    logic        w_flush_loss;

    // A flush only counts when it actually throws away a fetched word.
    assign w_flush_loss = w_redirect &&
                          ((r_count != '0) || (r_inflight && (r_tag_epoch == r_epoch)));

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_flush_loss && (r_perf_flushes != '1)) begin
                r_perf_flushes <= r_perf_flushes + 16'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
`endif

endmodule
`default_nettype wire
